// File: rtl/stereo_disparity.sv
`default_nettype none
//============================================================================
// Module   : stereo_disparity
// Purpose  : Finds the disparity between two calc strips with a SAD block
//            match. A fixed left window at REF_X is compared against right
//            windows shifted by d = 0..MAX_DISP-1. The d with the smallest
//            SAD is reported. On a tie the smaller d is kept.
// Ports    : sysclk            - clock for the logic and both RAM read ports
//            reset             - synchronous, active-high
//            start             - one-cycle pulse: both strips are complete
//            datal / datar     - left / right calc RAM read data
//            rdaddrl / rdaddrr - left / right read addresses
//            rdenl / rdenr     - read enables
//            busy              - scan in progress
//            done              - one-cycle pulse when the results update
//            disparity / sad   - best d and its SAD
//            valid             - best SAD is <= SAD_THRESH
// Revision : 1.0 - initial release
//============================================================================
module stereo_disparity #(
  parameter int ADDR_W     = 11,
  parameter int REF_X      = 128,
  parameter int WIN        = 16,
  parameter int MAX_DISP   = 64,
  parameter int DISP_W     = 6,
  parameter int RD_LAT     = 2,
  parameter int SAD_THRESH = 32
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        datal,
  input  logic [2:0]        datar,
  output logic [ADDR_W-1:0] rdaddrl,
  output logic [ADDR_W-1:0] rdaddrr,
  output logic              rdenl,
  output logic              rdenr,
  output logic              busy,
  output logic              done,
  output logic [DISP_W-1:0] disparity,
  output logic [9:0]        sad,
  output logic              valid
);

  // One counter serves both the READ phase (WIN cycles) and the DRAIN phase
  // (RD_LAT cycles).
  localparam int c_CNT_W = $clog2(WIN + RD_LAT + 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_READ  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;
  localparam logic [1:0] c_ST_CMP   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DISP_W-1:0]  r_d;
  logic [9:0]         r_acc;
  logic [9:0]         r_best_sad;
  logic [DISP_W-1:0]  r_best_d;
  logic [RD_LAT-1:0]  r_vld_pipe;

  logic               w_rden;
  logic               w_read_last;
  logic               w_drain_last;
  logic               w_last_d;
  logic               w_better;
  logic [9:0]         w_new_sad;
  logic [DISP_W-1:0]  w_new_d;
  logic [2:0]         w_diff;
  logic [ADDR_W-1:0]  w_addrl;
  logic [ADDR_W-1:0]  w_addrr;

  assign w_read_last  = (r_cnt == c_CNT_W'(WIN - 1));
  assign w_drain_last = (r_cnt == c_CNT_W'(RD_LAT - 1));
  assign w_last_d     = (r_d == DISP_W'(MAX_DISP - 1));

  // Strict compare: an equal SAD at a larger d never displaces the best.
  assign w_better  = (r_acc < r_best_sad);
  assign w_new_sad = w_better ? r_acc : r_best_sad;
  assign w_new_d   = w_better ? r_d   : r_best_d;

  assign w_diff = (datal > datar) ? (datal - datar) : (datar - datal);

  // REF_X >= MAX_DISP-1 keeps the right address from wrapping below zero.
  assign w_addrl = ADDR_W'(REF_X) + ADDR_W'(r_cnt);
  assign w_addrr = w_addrl - ADDR_W'(r_d);

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state. A start outside IDLE is simply not looked at.
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (start)        w_state_nxt = c_ST_READ;
      c_ST_READ:  if (w_read_last)  w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN: if (w_drain_last) w_state_nxt = c_ST_CMP;
      c_ST_CMP:   w_state_nxt = w_last_d ? c_ST_IDLE : c_ST_READ;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    w_rden  = (r_state == c_ST_READ);
    busy    = (r_state != c_ST_IDLE);
    rdenl   = w_rden;
    rdenr   = w_rden;
    rdaddrl = w_rden ? w_addrl : '0;
    rdaddrr = w_rden ? w_addrr : '0;
  end

  //--------------------------------------------------------------------------
  // Valid pipe: the top bit marks the cycle whose RAM data belongs to a read
  // issued RD_LAT cycles earlier.
  //--------------------------------------------------------------------------
  generate
    if (RD_LAT == 1) begin : g_vld_lat1
      always_ff @(posedge sysclk) begin
        if (reset) r_vld_pipe <= '0;
        else       r_vld_pipe <= w_rden;
      end
    end else begin : g_vld_latn
      always_ff @(posedge sysclk) begin
        if (reset) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[RD_LAT-2:0], w_rden};
      end
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Scan datapath: counters, accumulator, running best
  //--------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_d        <= '0;
      r_acc      <= '0;
      r_best_sad <= 10'h3FF;
      r_best_d   <= '0;
    end else begin
      // The last read data arrives in the final DRAIN cycle, so the
      // accumulator is complete when CMP sees it.
      if (r_state == c_ST_CMP)
        r_acc <= '0;
      else if (r_vld_pipe[RD_LAT-1])
        r_acc <= r_acc + {7'd0, w_diff};

      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_d        <= '0;
            r_acc      <= '0;
            r_best_sad <= 10'h3FF;
            r_best_d   <= '0;
          end
        end
        c_ST_READ:  r_cnt <= w_read_last  ? '0 : r_cnt + 1'b1;
        c_ST_DRAIN: r_cnt <= w_drain_last ? '0 : r_cnt + 1'b1;
        c_ST_CMP: begin
          r_cnt      <= '0;
          r_best_sad <= w_new_sad;
          r_best_d   <= w_new_d;
          if (!w_last_d) r_d <= r_d + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Result registers: loaded only by the CMP cycle that ends the scan.
  //--------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (reset) begin
      done      <= 1'b0;
      disparity <= '0;
      sad       <= '0;
      valid     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == c_ST_CMP && w_last_d) begin
        done      <= 1'b1;
        disparity <= w_new_d;
        sad       <= w_new_sad;
        valid     <= (w_new_sad <= 10'(SAD_THRESH));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stereo_disparity.sv
`default_nettype none
//============================================================================
// Module   : tb_stereo_disparity
// Purpose  : Self-checking bench for stereo_disparity. Calc RAMs are
//            modelled with a RD_LAT-cycle read pipe. Expected results come
//            from a direct SAD search over the strip arrays.
// Revision : 1.0 - initial release
//============================================================================
module tb_stereo_disparity;

  localparam int ADDR_W   = 11;
  localparam int REF_X    = 128;
  localparam int WIN      = 16;
  localparam int MAX_DISP = 64;
  localparam int DISP_W   = 6;
  localparam int RD_LAT   = 2;
  localparam int THRESH   = 32;
  localparam int DONE_CYC = 1 + MAX_DISP * (WIN + RD_LAT) + (MAX_DISP - 1);
  localparam int N_READS  = MAX_DISP * WIN;

  logic              sysclk;
  logic              reset;
  logic              start;
  logic [2:0]        datal;
  logic [2:0]        datar;
  logic [ADDR_W-1:0] rdaddrl;
  logic [ADDR_W-1:0] rdaddrr;
  logic              rdenl;
  logic              rdenr;
  logic              busy;
  logic              done;
  logic [DISP_W-1:0] disparity;
  logic [9:0]        sad;
  logic              valid;

  logic [2:0] lmem [0:2047];
  logic [2:0] rmem [0:2047];
  logic [2:0] ql1, qr1;

  int n_vec = 0;
  int n_err = 0;
  int cnt_l = 0;
  int cnt_r = 0;
  int rd_idx = 0;

  stereo_disparity #(
    .ADDR_W(ADDR_W), .REF_X(REF_X), .WIN(WIN), .MAX_DISP(MAX_DISP),
    .DISP_W(DISP_W), .RD_LAT(RD_LAT), .SAD_THRESH(THRESH)
  ) dut (
    .sysclk(sysclk), .reset(reset), .start(start),
    .datal(datal), .datar(datar),
    .rdaddrl(rdaddrl), .rdaddrr(rdaddrr), .rdenl(rdenl), .rdenr(rdenr),
    .busy(busy), .done(done), .disparity(disparity), .sad(sad), .valid(valid)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Two-stage read pipe per RAM: q is valid two cycles after the address.
  always @(posedge sysclk) begin
    if (rdenl === 1'b1) ql1 <= lmem[rdaddrl];
    if (rdenr === 1'b1) qr1 <= rmem[rdaddrr];
    datal <= ql1;
    datar <= qr1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Address monitor: the k-th read of a scan targets i = k%WIN, d = k/WIN.
  always @(negedge sysclk) begin
    if (rdenl === 1'b1) cnt_l++;
    if (rdenr === 1'b1) cnt_r++;
    if (reset !== 1'b0 || busy !== 1'b1) begin
      rd_idx = 0;
    end else if (rdenl === 1'b1) begin
      chk("rdaddrl", 32'(rdaddrl), 32'(REF_X + rd_idx % WIN));
      chk("rdaddrr", 32'(rdaddrr), 32'(REF_X + rd_idx % WIN - rd_idx / WIN));
      chk("rdenr_with_rdenl", 32'(rdenr), 32'd1);
      rd_idx++;
    end
  end

  // Exhaustive SAD search over the strips.
  function automatic void model(output int bd, output int bs);
    int s, a, b;
    bs = 1023;
    bd = 0;
    for (int d = 0; d < MAX_DISP; d++) begin
      s = 0;
      for (int i = 0; i < WIN; i++) begin
        a = int'(lmem[REF_X + i]);
        b = int'(rmem[REF_X + i - d]);
        s += (a > b) ? (a - b) : (b - a);
      end
      if (s < bs) begin
        bs = s;
        bd = d;
      end
    end
  endfunction

  // mode 0: x%8 both; 1: random L, R shifted by sh; 2: all 3; 3: L 7 R 0;
  // 4: independent random; 5: shifted by sh with sparse noise on R.
  task automatic fill(input int mode, input int sh);
    for (int x = 0; x < 2048; x++) lmem[x] = 3'($urandom);
    for (int x = 0; x < 2048; x++) begin
      case (mode)
        0: begin lmem[x] = 3'(x % 8); rmem[x] = 3'(x % 8); end
        2: begin lmem[x] = 3'd3; rmem[x] = 3'd3; end
        3: begin lmem[x] = 3'd7; rmem[x] = 3'd0; end
        4: rmem[x] = 3'($urandom);
        default: begin
          rmem[x] = (x + sh < 2048) ? lmem[x + sh] : 3'($urandom);
          if (mode == 5 && $urandom_range(9, 0) == 0) rmem[x] = 3'($urandom);
        end
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdaddrl"}, 32'(rdaddrl), 0);
    chk({tag, "_rdaddrr"}, 32'(rdaddrr), 0);
    chk({tag, "_rdenl"}, 32'(rdenl), 0);
    chk({tag, "_rdenr"}, 32'(rdenr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_disparity"}, 32'(disparity), 0);
    chk({tag, "_sad"}, 32'(sad), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
  endtask

  // Pulses start in the current cycle (called at a negedge) and waits for
  // done. extra_at >= 0 pulses start again in that cycle of the scan.
  task automatic run_scan(input string tag, input int extra_at);
    int bd, bs, cyc, l0, r0;
    model(bd, bs);
    l0 = cnt_l;
    r0 = cnt_r;
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    chk({tag, "_busy_c0"}, 32'(busy), 1);
    chk({tag, "_rden_c0"}, 32'(rdenl), 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      start = (cyc == extra_at);
      @(negedge sysclk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(DONE_CYC));
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
    chk({tag, "_disparity"}, 32'(disparity), 32'(bd));
    chk({tag, "_sad"}, 32'(sad), 32'(bs));
    chk({tag, "_valid"}, 32'(valid), 32'(bs <= THRESH));
    chk({tag, "_rdenl_count"}, 32'(cnt_l - l0), 32'(N_READS));
    chk({tag, "_rdenr_count"}, 32'(cnt_r - r0), 32'(N_READS));
    @(negedge sysclk);
    chk({tag, "_done_pulse"}, 32'(done), 0);
    chk({tag, "_disparity_hold"}, 32'(disparity), 32'(bd));
    chk({tag, "_sad_hold"}, 32'(sad), 32'(bs));
  endtask

  initial begin
    int n_done, n_rden;
    reset = 1'b1;
    start = 1'b0;
    fill(0, 0);
    @(negedge sysclk);
    check_reset_outputs("por");
    @(negedge sysclk);
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    check_reset_outputs("idle");

    // Identical strips, then spec-derived constants on top of the model.
    fill(0, 0);
    run_scan("ident", -1);
    chk("ident_disp_const", 32'(disparity), 0);
    chk("ident_sad_const", 32'(sad), 0);

    fill(1, 10);
    run_scan("shift10", -1);
    chk("shift10_disp_const", 32'(disparity), 10);
    chk("shift10_valid_const", 32'(valid), 1);

    fill(2, 0);
    run_scan("ties", -1);
    chk("ties_disp_const", 32'(disparity), 0);

    fill(3, 0);
    run_scan("mismatch", -1);
    chk("mismatch_sad_const", 32'(sad), 112);
    chk("mismatch_valid_const", 32'(valid), 0);

    fill(5, int'($urandom_range(MAX_DISP - 1, 1)));
    run_scan("rand_noisy", -1);
    fill(4, 0);
    run_scan("rand_indep", -1);
    fill(1, int'($urandom_range(MAX_DISP - 1, 0)));
    run_scan("rand_shift", -1);

    // Back-to-back: a start at cycle 600 is ignored; a start the cycle after
    // done begins a fresh full-length scan.
    fill(1, 37);
    run_scan("b2b_first", 600);
    run_scan("b2b_third", -1);

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    start = 1'b0;
    check_reset_outputs("rst_start");
    @(negedge sysclk);
    chk("rst_start_no_busy", 32'(busy), 0);

    // Reset mid-scan at cycle 500, held for 3 cycles.
    fill(4, 0);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    for (int c = 0; c < 500; c++) @(negedge sysclk);
    chk("midscan_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(negedge sysclk);
    check_reset_outputs("midscan");
    n_rden = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge sysclk);
      if (rdenl === 1'b1 || rdenr === 1'b1) n_rden++;
    end
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge sysclk);
      if (done !== 1'b0) n_done++;
      if (rdenl !== 1'b0 || rdenr !== 1'b0) n_rden++;
    end
    chk("midscan_no_done", 32'(n_done), 0);
    chk("midscan_no_rden", 32'(n_rden), 0);
    chk("midscan_idle", 32'(busy), 0);

    fill(1, 5);
    run_scan("recover", -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
